pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline sequencing controller for the fetch/decode/execute core. It sits beside the IF_ID/ID_EX pipeline registers and the decoder. It inspects the instruction held in IF_ID and tracks in-flight register writes in a scoreboard, and from these it drives the fetch, IF_ID and ID_EX enables. It inserts bubbles on read-after-write hazards, freezes fetch until branches resolve, and halts the pipeline on HLT.

## Interface
- WB_LAT, 3: cycles from issue into ID_EX until the register-file write is visible to decode (1..7).
- clock  in  1  pipeline clock, all state on posedge.
- reset  in  1  synchronous, active-high.
- if_valid  in  1  IF_ID holds a valid instruction.
- if_instr  in  32  IF_ID[31:0]: opcode [31:26], rs [25:21], rt [20:16], rd [15:11].
- br_resolve  in  1  execute stage reports branch outcome (1-cycle pulse).
- br_taken  in  1  outcome qualifier, valid with br_resolve.
- resume  in  1  leave HALTED.
- pc_en  out  1  PC advances / loads branch target.
- if_id_en  out  1  IF_ID load enable.
- id_ex_en  out  1  ID_EX load enable.
- id_ex_bubble  out  1  ID_EX loads NOP (opcode 6'b001110, all other fields 0).
- if_id_flush  out  1  IF_ID cleared to invalid.
- halted  out  1  pipeline stopped by HLT.
- stall_cnt  out  16  saturating count of hazard-stall cycles.

## Operation
- Opcode classes:
  - reads rs+rt: ADD, SUB, AND, OR, XOR, MUL, BNE.
  - reads rs only: SHL, SHR, MOV, ADI.
  - reads none: LI, BR, HLT, NOP.
  - writes rd: ADD, SUB, LI, SHL, SHR, AND, OR, XOR, MOV, ADI, MUL.
  - Opcodes 0x0F–0x3F are treated as NOP.
- No register is hardwired; r0 is tracked like any other register.
- Scoreboard: 32 counters of 3 bits.
  - On issue of a writer, cnt[rd] <= WB_LAT.
  - Otherwise, every nonzero counter decrements each cycle.
  - A load and a decrement on the same register in the same cycle: the load wins.
- hazard = if_valid & ((reads rs & cnt[rs]!=0) | (reads rt & cnt[rt]!=0)).
- FSM states: RUN, BR_WAIT, HALTED.
- RUN:
  - !if_valid: pc_en=1, if_id_en=1, id_ex_en=1, bubble=1.
  - hazard: pc_en=0, if_id_en=0, id_ex_en=1, bubble=1; stall_cnt++ (saturates at 0xFFFF).
  - Otherwise issue: all enables=1, bubble=0, scoreboard updated.
    - Issued BR or BNE -> BR_WAIT.
    - Issued HLT -> HALTED.
- BR_WAIT:
  - pc_en=0, if_id_en=0, id_ex_en=1, bubble=1 until br_resolve.
  - br_resolve & br_taken: pc_en=1, if_id_flush=1, -> RUN.
  - br_resolve & !br_taken: pc_en=1, if_id_en=1, -> RUN.
- HALTED:
  - halted=1; pc_en=if_id_en=0; id_ex_en=1, bubble=1.
  - Scoreboard keeps draining.
  - resume -> RUN next cycle.
- br_resolve outside BR_WAIT is ignored. resume outside HALTED is ignored.
- Reset (any state, mid-branch or mid-halt):
  - state=RUN, all counters=0, stall_cnt=0.
  - While reset=1, outputs are pc_en=0, if_id_en=0, id_ex_en=1, bubble=1, flush=0, halted=0.

## Timing
- Enables and bubble are combinational from state, scoreboard and inputs in the same cycle.
- Scoreboard, state and stall_cnt update at posedge.
- Hazard checks use pre-edge counter values.
- Writer issued at edge N: a dependent instruction stalls for exactly WB_LAT cycles and issues at edge N+WB_LAT+1 (WB_LAT=3: 3 stall cycles).
- Independent back-to-back instructions issue one per cycle with no bubble.
- Branch: at least 1 bubble cycle; RUN resumes the cycle after br_resolve.
- br_resolve in the same cycle the branch issues is ignored (still RUN).
- HLT: halted rises the cycle after HLT issues.

## Structure
- pipe_ctrl_pkg holds:
  - the 15 opcode localparams (ADD=0 … NOP=14);
  - state encoding (RUN=0, BR_WAIT=1, HALTED=2);
  - functions reads_rs, reads_rt, writes_rd.
- Sub-module pipe_scoreboard owns the 32 counters. Interface: issue_we, issue_rd, rs, rt, busy_rs, busy_rt, clock, reset.
- pipe_ctrl holds the FSM, output decode and stall_cnt.

## Test plan
- Dependency stall: reset, then ADD r3,r1,r2 (0x00221800) followed by SUB r4,r3,r1 (0x04612000).
  - Expect 3 bubble cycles with pc_en=0, then SUB issues.
  - stall_cnt=3.
- No stall: ADD r3,r1,r2 then XOR r5,r1,r2 (0x1C222800).
  - Expect consecutive issues, bubble=0, stall_cnt=0.
- Taken branch: BNE r1,r2 (0x24220000); br_resolve=1, br_taken=1 three cycles later.
  - Expect 3 bubbles, then one cycle with pc_en=1, if_id_flush=1, then RUN.
- Not-taken branch: same as above with br_taken=0.
  - Expect if_id_flush=0 and if_id_en=1 on the resolve cycle.
- Halt: HLT (0x34000000).
  - Expect halted=1 from the next cycle and pc_en=0 held for 10 cycles.
  - resume -> halted=0 the next cycle.
- Reset mid-operation: assert reset during BR_WAIT with cnt[r3]=2.
  - After reset, SUB r4,r3,r1 issues with no stall.
  - stall_cnt=0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared opcodes, controller state encoding and operand-use decode
// for the fetch/decode/execute sequencing controller.
package pipe_ctrl_pkg;

  localparam logic [5:0] OP_ADD = 6'd0;
  localparam logic [5:0] OP_SUB = 6'd1;
  localparam logic [5:0] OP_LI  = 6'd2;
  localparam logic [5:0] OP_SHL = 6'd3;
  localparam logic [5:0] OP_SHR = 6'd4;
  localparam logic [5:0] OP_AND = 6'd5;
  localparam logic [5:0] OP_OR  = 6'd6;
  localparam logic [5:0] OP_XOR = 6'd7;
  localparam logic [5:0] OP_BR  = 6'd8;
  localparam logic [5:0] OP_BNE = 6'd9;
  localparam logic [5:0] OP_MOV = 6'd10;
  localparam logic [5:0] OP_ADI = 6'd11;
  localparam logic [5:0] OP_MUL = 6'd12;
  localparam logic [5:0] OP_HLT = 6'd13;
  localparam logic [5:0] OP_NOP = 6'd14;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    BR_WAIT = 2'd1,
    HALTED  = 2'd2
  } state_t;

  function automatic logic reads_rs(
    input logic [5:0] op
  );
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_MUL, OP_BNE, OP_SHL,
      OP_SHR, OP_MOV, OP_ADI:
        return 1'b1;
      default:
        return 1'b0;
    endcase
  endfunction

  function automatic logic reads_rt(
    input logic [5:0] op
  );
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_MUL, OP_BNE:
        return 1'b1;
      default:
        return 1'b0;
    endcase
  endfunction

  function automatic logic writes_rd(
    input logic [5:0] op
  );
    case (op)
      OP_ADD, OP_SUB, OP_LI, OP_SHL,
      OP_SHR, OP_AND, OP_OR, OP_XOR,
      OP_MOV, OP_ADI, OP_MUL:
        return 1'b1;
      default:
        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_scoreboard.sv
// Per-register countdown of cycles until an in-flight write
// becomes visible to decode.
module pipe_scoreboard
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned WB_LAT = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       issue_we,
  input  logic [4:0] issue_rd,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  output logic       busy_rs,
  output logic       busy_rt
);

  logic [2:0] cnt [32];

  // A fresh load on rd takes priority over its drain step.
  always_ff @(posedge clock) begin
    for (int i = 0; i < 32; i++) begin
      if (reset)
        cnt[i] <= '0;
      else if (issue_we && issue_rd == 5'(i))
        cnt[i] <= 3'(WB_LAT);
      else if (cnt[i] != '0)
        cnt[i] <= cnt[i] - 3'd1;
    end
  end

  assign busy_rs = (cnt[rs] != '0);
  assign busy_rt = (cnt[rt] != '0);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: RAW stalls, branch freeze
// and halt handling for the IF_ID / ID_EX registers.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned WB_LAT = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_valid,
  input  logic [31:0] if_instr,
  input  logic        br_resolve,
  input  logic        br_taken,
  input  logic        resume,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        id_ex_en,
  output logic        id_ex_bubble,
  output logic        if_id_flush,
  output logic        halted,
  output logic [15:0] stall_cnt
);

  state_t     state_q;
  state_t     state_d;
  logic [5:0] op;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;
  logic       busy_rs;
  logic       busy_rt;
  logic       hazard;
  logic       issue;
  logic       stall_inc;
  logic       unused_bits;

  assign op = if_instr[31:26];
  assign rs = if_instr[25:21];
  assign rt = if_instr[20:16];
  assign rd = if_instr[15:11];
  assign unused_bits = ^if_instr[10:0];

  assign hazard = if_valid &
    ((reads_rs(op) & busy_rs) |
     (reads_rt(op) & busy_rt));

  assign issue = !reset && state_q == RUN &&
    if_valid && !hazard;

  pipe_scoreboard #(
    .WB_LAT(WB_LAT)
  ) u_sb (
    .clock   (clock),
    .reset   (reset),
    .issue_we(issue & writes_rd(op)),
    .issue_rd(rd),
    .rs      (rs),
    .rt      (rt),
    .busy_rs (busy_rs),
    .busy_rt (busy_rt)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= RUN;
      stall_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (stall_inc && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

  // Default is the frozen front end feeding NOPs into ID_EX.
  always_comb begin
    state_d      = state_q;
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    id_ex_en     = 1'b1;
    id_ex_bubble = 1'b1;
    if_id_flush  = 1'b0;
    halted       = 1'b0;
    stall_inc    = 1'b0;
    if (!reset) begin
      unique case (state_q)
        RUN: begin
          if (!if_valid) begin
            pc_en    = 1'b1;
            if_id_en = 1'b1;
          end else if (hazard) begin
            stall_inc = 1'b1;
          end else begin
            pc_en        = 1'b1;
            if_id_en     = 1'b1;
            id_ex_bubble = 1'b0;
            if (op == OP_BR || op == OP_BNE)
              state_d = BR_WAIT;
            else if (op == OP_HLT)
              state_d = HALTED;
          end
        end
        BR_WAIT: begin
          if (br_resolve) begin
            pc_en       = 1'b1;
            if_id_flush = br_taken;
            if_id_en    = !br_taken;
            state_d     = RUN;
          end
        end
        HALTED: begin
          halted = 1'b1;
          if (resume)
            state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed-vector bench for pipe_ctrl with hand-computed
// enables, bubbles, state and stall counts.
module tb_pipe_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_valid;
  logic [31:0] if_instr;
  logic        br_resolve;
  logic        br_taken;
  logic        resume;
  logic        pc_en;
  logic        if_id_en;
  logic        id_ex_en;
  logic        id_ex_bubble;
  logic        if_id_flush;
  logic        halted;
  logic [15:0] stall_cnt;

  int n_chk = 0;
  int n_err = 0;

  localparam logic [31:0] I_ADD  = 32'h0022_1800;
  localparam logic [31:0] I_SUB  = 32'h0461_2000;
  localparam logic [31:0] I_XOR  = 32'h1C22_2800;
  localparam logic [31:0] I_BNE  = 32'h2422_0000;
  localparam logic [31:0] I_HLT  = 32'h3400_0000;
  localparam logic [31:0] I_ADD0 = 32'h0022_0000;
  localparam logic [31:0] I_SUB0 = 32'h0420_2000;
  localparam logic [31:0] I_OPF  = 32'h3C61_1800;

  pipe_ctrl #(.WB_LAT(3)) dut (
    .clock       (clock),
    .reset       (reset),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .br_resolve  (br_resolve),
    .br_taken    (br_taken),
    .resume      (resume),
    .pc_en       (pc_en),
    .if_id_en    (if_id_en),
    .id_ex_en    (id_ex_en),
    .id_ex_bubble(id_ex_bubble),
    .if_id_flush (if_id_flush),
    .halted      (halted),
    .stall_cnt   (stall_cnt)
  );

  always #5 clock = ~clock;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
        tag, got, exp);
    end
  endtask

  task automatic drive(
    input logic        rst,
    input logic        v,
    input logic [31:0] ins,
    input logic        res,
    input logic        tk,
    input logic        rsm
  );
    reset      = rst;
    if_valid   = v;
    if_instr   = ins;
    br_resolve = res;
    br_taken   = tk;
    resume     = rsm;
    #2;
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // {pc_en, if_id_en, id_ex_en, bubble, flush, halted}
  task automatic outs(
    input string      tag,
    input logic [5:0] exp
  );
    check(tag, {26'd0, pc_en, if_id_en, id_ex_en,
      id_ex_bubble, if_id_flush, halted}, {26'd0, exp});
  endtask

  task automatic do_reset();
    drive(1, 1, I_ADD, 1, 1, 1);
    outs("reset_outs", 6'b001100);
    cyc();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 32'd0, 0, 0, 0);
      cyc();
    end
  endtask

  initial begin
    @(posedge clock);
    #1;

    // RAW stall on r3
    do_reset();
    check("reset_stall_cnt", 32'(stall_cnt), 0);
    drive(0, 0, 32'd0, 0, 0, 0);
    outs("idle_run", 6'b111100);
    drive(0, 1, I_ADD, 0, 0, 0);
    outs("add_issue", 6'b111000);
    cyc();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, I_SUB, 0, 0, 0);
      outs("sub_stall", 6'b001100);
      cyc();
    end
    drive(0, 1, I_SUB, 0, 0, 0);
    outs("sub_issue", 6'b111000);
    cyc();
    drive(0, 0, 32'd0, 0, 0, 0);
    check("stall_cnt_3", 32'(stall_cnt), 3);
    idle(4);

    // independent back-to-back, unknown opcode
    do_reset();
    drive(0, 1, I_ADD, 0, 0, 0);
    outs("add_issue2", 6'b111000);
    cyc();
    drive(0, 1, I_XOR, 0, 0, 0);
    outs("xor_issue", 6'b111000);
    cyc();
    drive(0, 1, I_OPF, 0, 0, 0);
    outs("opf_as_nop", 6'b111000);
    cyc();
    drive(0, 0, 32'd0, 0, 0, 0);
    check("stall_cnt_0", 32'(stall_cnt), 0);

    // r0 is tracked like any other register
    do_reset();
    drive(0, 1, I_ADD0, 0, 0, 0);
    cyc();
    drive(0, 1, I_SUB0, 0, 0, 0);
    outs("r0_stall", 6'b001100);
    cyc();
    cyc();
    cyc();
    outs("r0_issue", 6'b111000);
    cyc();
    drive(0, 0, 32'd0, 0, 0, 0);
    check("r0_stall_cnt", 32'(stall_cnt), 3);

    // taken branch
    do_reset();
    drive(0, 1, I_BNE, 0, 0, 0);
    outs("bne_issue", 6'b111000);
    cyc();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, I_ADD, 0, 0, 0);
      outs("br_wait", 6'b001100);
      cyc();
    end
    drive(0, 1, I_ADD, 1, 1, 0);
    outs("br_taken", 6'b101110);
    cyc();
    drive(0, 0, 32'd0, 1, 1, 0);
    outs("br_taken_run", 6'b111100);
    cyc();

    // not taken; resolve on issue cycle ignored
    do_reset();
    drive(0, 1, I_BNE, 1, 0, 0);
    outs("bne_issue_res", 6'b111000);
    cyc();
    drive(0, 1, I_ADD, 0, 0, 0);
    outs("br_wait_nt", 6'b001100);
    cyc();
    drive(0, 1, I_ADD, 1, 0, 0);
    outs("br_not_taken", 6'b111100);
    cyc();
    drive(0, 1, I_XOR, 0, 0, 0);
    outs("br_nt_run", 6'b111000);
    cyc();

    // halt, scoreboard drains while halted
    do_reset();
    drive(0, 1, I_ADD, 0, 0, 0);
    cyc();
    drive(0, 1, I_HLT, 0, 0, 1);
    outs("hlt_issue", 6'b111000);
    cyc();
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, I_SUB, 1, 1, i == 9);
      outs("halted", 6'b001101);
      cyc();
    end
    drive(0, 1, I_SUB, 0, 0, 0);
    outs("resumed_issue", 6'b111000);
    cyc();
    drive(0, 0, 32'd0, 0, 0, 0);
    check("halt_stall_cnt", 32'(stall_cnt), 0);

    // reset in BR_WAIT with r3 busy
    do_reset();
    drive(0, 1, I_ADD, 0, 0, 0);
    cyc();
    drive(0, 1, I_BNE, 0, 0, 0);
    outs("bne_issue3", 6'b111000);
    cyc();
    drive(0, 1, I_ADD, 0, 0, 0);
    outs("br_wait3", 6'b001100);
    cyc();
    do_reset();
    drive(0, 1, I_SUB, 0, 0, 0);
    outs("post_reset_sub", 6'b111000);
    cyc();
    drive(0, 0, 32'd0, 0, 0, 0);
    check("post_reset_cnt", 32'(stall_cnt), 0);

    $display("Simulation finished: %0d checks, %0d errors",
      n_chk, n_err);
    $finish;
  end

endmodule
